// File: rtl/pipe_hazard_ctrl.sv
// Hazard and multdiv control beside the D/X latch: multdiv start/wait/timeout,
// taken-branch flush and single-bubble load-use stall. All outputs are combinational.
module pipe_hazard_ctrl #(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 7
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] fd_ir,
   input  logic [31:0] dx_ir,
   input  logic        branch_taken,
   input  logic        data_resultRDY,
   input  logic        data_exception,
   output logic        pc_enable,
   output logic        fd_enable,
   output logic        dx_enable,
   output logic [1:0]  dx_ir_sel,
   output logic        fd_flush,
   output logic        xm_nop,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic        md_busy,
   output logic        md_done,
   output logic        md_exception
);

   localparam logic [4:0] OP_ALU   = 5'b00000;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] ALU_MUL  = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;
   localparam logic [1:0] SEL_FD   = 2'b00;
   localparam logic [1:0] SEL_NOP  = 2'b01;
   localparam logic [1:0] SEL_HOLD = 2'b10;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

   typedef enum logic {IDLE, MD_WAIT} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;

   function automatic logic is_md(input logic [31:0] ir);
      return (ir[31:27] == OP_ALU) && ((ir[6:2] == ALU_MUL) || (ir[6:2] == ALU_DIV));
   endfunction

   function automatic logic is_lw(input logic [31:0] ir);
      return ir[31:27] == OP_LW;
   endfunction

   // Stores and compare-branches read their rd field as a source operand.
   function automatic logic rd_is_src(input logic [4:0] op);
      return (op == OP_SW) || (op == OP_BNE) || (op == OP_BLT);
   endfunction

   logic [4:0] dx_rd, fd_rd, fd_rs, fd_rt;
   logic       load_use;
   logic       timeout;

   assign dx_rd = dx_ir[26:22];
   assign fd_rd = fd_ir[26:22];
   assign fd_rs = fd_ir[21:17];
   assign fd_rt = fd_ir[16:12];

   assign load_use = is_lw(dx_ir) && (dx_rd != 5'd0) &&
                     ((dx_rd == fd_rs) || (dx_rd == fd_rt) ||
                      (rd_is_src(fd_ir[31:27]) && (dx_rd == fd_rd)));

   assign timeout = (cnt == CNT_LAST);

   logic unused_ir_bits;
   assign unused_ir_bits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      pc_enable    = 1'b1;
      fd_enable    = 1'b1;
      dx_enable    = 1'b1;
      dx_ir_sel    = SEL_FD;
      fd_flush     = 1'b0;
      xm_nop       = 1'b0;
      ctrl_MULT    = 1'b0;
      ctrl_DIV     = 1'b0;
      md_busy      = 1'b0;
      md_done      = 1'b0;
      md_exception = 1'b0;

      // Reset forces the pass-through outputs and drops any pending multdiv result.
      if (!reset) begin
         case (state)
            IDLE: begin
               if (is_md(dx_ir)) begin
                  ctrl_MULT  = (dx_ir[6:2] == ALU_MUL);
                  ctrl_DIV   = (dx_ir[6:2] == ALU_DIV);
                  pc_enable  = 1'b0;
                  fd_enable  = 1'b0;
                  dx_enable  = 1'b0;
                  dx_ir_sel  = SEL_HOLD;
                  xm_nop     = 1'b1;
                  cnt_next   = '0;
                  state_next = MD_WAIT;
               end else if (branch_taken) begin
                  fd_flush  = 1'b1;
                  dx_ir_sel = SEL_NOP;
               end else if (load_use) begin
                  pc_enable = 1'b0;
                  fd_enable = 1'b0;
                  dx_ir_sel = SEL_NOP;
               end
            end
            MD_WAIT: begin
               md_busy = 1'b1;
               if (data_resultRDY || timeout) begin
                  md_done      = 1'b1;
                  md_exception = data_resultRDY ? data_exception : 1'b1;
                  state_next   = IDLE;
               end else begin
                  pc_enable = 1'b0;
                  fd_enable = 1'b0;
                  dx_enable = 1'b0;
                  dx_ir_sel = SEL_HOLD;
                  xm_nop    = 1'b1;
                  cnt_next  = cnt + CNT_W'(1);
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

endmodule
